// File: rtl/demux4_seq.sv
// demux4_seq: routes one input stream to one of four registered outputs for a
// bounded number of words per run pulse, fixed or round-robin. Option macro:
// DEMUX4_SEQ_ZERO_UNSEL_EN (clear the non-selected outputs on each write).
//
// +--------------------------------------------------------------------------+
// | Module   : demux4_seq                                                    |
// | Function : 1:4 sequential demultiplexer functional unit                  |
// | Options  : DEMUX4_SEQ_ZERO_UNSEL_EN                                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module demux4_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              running,
  input  logic              run,
  output logic              done,
  input  logic [DATA_W-1:0] in0,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  input  logic [1:0]        sel,
  input  logic              auto_rr,
  input  logic [CNT_W-1:0]  period,
  input  logic [CNT_W-1:0]  amount
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [0:0]        state;
  logic [1:0]        idx;
  logic [CNT_W-1:0]  per_cnt;
  logic [CNT_W-1:0]  item_cnt;
  logic              auto_rr_q;
  logic [CNT_W-1:0]  period_q;
  logic [CNT_W-1:0]  amount_q;
  logic [DATA_W-1:0] out_q [4];

  logic [CNT_W-1:0]  per_last;
  logic              write_en;
  logic              last_item;

  // A period of zero behaves as a period of one.
  assign per_last  = (period_q == '0) ? '0 : period_q - {{(CNT_W-1){1'b0}}, 1'b1};
  assign write_en  = (state == ACTIVE) && running && !run;
  assign last_item = (item_cnt == amount_q - {{(CNT_W-1){1'b0}}, 1'b1});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      per_cnt   <= '0;
      item_cnt  <= '0;
      auto_rr_q <= 1'b0;
      period_q  <= '0;
      amount_q  <= '0;
      for (int i = 0; i < 4; i++) out_q[i] <= '0;
    end else if (run) begin
      idx       <= sel;
      per_cnt   <= '0;
      item_cnt  <= '0;
      auto_rr_q <= auto_rr;
      period_q  <= period;
      amount_q  <= amount;
      state     <= (amount != '0) ? ACTIVE : IDLE;
    end else if (write_en) begin
      for (int i = 0; i < 4; i++) begin
        if (idx == 2'(i)) begin
          out_q[i] <= in0;
        end else begin
`ifdef DEMUX4_SEQ_ZERO_UNSEL_EN
          out_q[i] <= '0;
`else
          out_q[i] <= out_q[i];
`endif
        end
      end
      item_cnt <= item_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (auto_rr_q) begin
        if (per_cnt == per_last) begin
          per_cnt <= '0;
          idx     <= idx + 2'd1;
        end else begin
          per_cnt <= per_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      if (last_item) state <= IDLE;
    end
  end

  assign done = (state == IDLE);
  assign out0 = out_q[0];
  assign out1 = out_q[1];
  assign out2 = out_q[2];
  assign out3 = out_q[3];

endmodule

`default_nettype wire

// File: tb/tb_demux4_seq.sv
// Self-checking bench for demux4_seq: directed vector table plus hand-written
// sequences for async reset mid-transfer and the unselected-output clear option.
`default_nettype none

module tb_demux4_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        running = 1'b0;
  logic        run = 1'b0;
  logic        done;
  logic [31:0] in0 = '0;
  logic [31:0] out0, out1, out2, out3;
  logic [1:0]  sel = '0;
  logic        auto_rr = 1'b0;
  logic [15:0] period = '0;
  logic [15:0] amount = '0;

  int errors = 0;
  int checks = 0;

`ifdef DEMUX4_SEQ_ZERO_UNSEL_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  demux4_seq #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .running(running), .run(run), .done(done),
    .in0(in0), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .sel(sel), .auto_rr(auto_rr), .period(period), .amount(amount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        run;
    logic        running;
    logic [31:0] in0;
    logic [1:0]  sel;
    logic        auto_rr;
    logic [15:0] period;
    logic [15:0] amount;
    logic        wr;     // a write is expected on this edge
    logic [1:0]  widx;   // destination of that write
    logic        done;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_out [4];

  function automatic vec_t v(input logic r, input logic rn, input logic [31:0] d,
                             input logic [1:0] s, input logic a, input logic [15:0] p,
                             input logic [15:0] m, input logic w, input logic [1:0] wi,
                             input logic dn);
    vec_t t;
    t.run = r; t.running = rn; t.in0 = d; t.sel = s; t.auto_rr = a;
    t.period = p; t.amount = m; t.wr = w; t.widx = wi; t.done = dn;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, " out0"}, out0, exp_out[0]);
    chk({tag, " out1"}, out1, exp_out[1]);
    chk({tag, " out2"}, out2, exp_out[2]);
    chk({tag, " out3"}, out3, exp_out[3]);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) exp_out[i] = '0;

    // Fixed route to out2; config inputs changed mid-transfer must be ignored.
    vecs.push_back(v(1, 1, 32'h0,  2, 0, 0, 3, 0, 0, 0));
    vecs.push_back(v(0, 1, 32'hA,  0, 1, 1, 1, 1, 2, 0));
    vecs.push_back(v(0, 1, 32'hB,  0, 1, 1, 1, 1, 2, 0));
    vecs.push_back(v(0, 1, 32'hC,  0, 1, 1, 1, 1, 2, 1));
    vecs.push_back(v(0, 1, 32'hD,  0, 1, 1, 1, 0, 0, 1));
    // Round-robin from out3, period 2, six words; wraps 3 -> 0.
    vecs.push_back(v(1, 1, 32'h0,  3, 1, 2, 6, 0, 0, 0));
    vecs.push_back(v(0, 1, 32'h1,  0, 0, 0, 0, 1, 3, 0));
    vecs.push_back(v(0, 1, 32'h2,  0, 0, 0, 0, 1, 3, 0));
    vecs.push_back(v(0, 1, 32'h3,  0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 1, 32'h4,  0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 1, 32'h5,  0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(v(0, 1, 32'h6,  0, 0, 0, 0, 1, 1, 1));
    // period=0 acts as 1; two stall cycles after the first word.
    vecs.push_back(v(1, 1, 32'h0,  0, 1, 0, 4, 0, 0, 0));
    vecs.push_back(v(0, 1, 32'h21, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 32'h99, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 32'h98, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 32'h22, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(v(0, 1, 32'h23, 0, 0, 0, 0, 1, 2, 0));
    vecs.push_back(v(0, 1, 32'h24, 0, 0, 0, 0, 1, 3, 1));
    // Restart after 2 of 5 words, with running low on the restart cycle.
    vecs.push_back(v(1, 1, 32'h0,  1, 0, 0, 5, 0, 0, 0));
    vecs.push_back(v(0, 1, 32'h31, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(v(0, 1, 32'h32, 0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(v(1, 0, 32'h0,  2, 0, 0, 5, 0, 0, 0));
    vecs.push_back(v(0, 1, 32'h41, 0, 0, 0, 0, 1, 2, 0));
    vecs.push_back(v(0, 1, 32'h42, 0, 0, 0, 0, 1, 2, 0));
    vecs.push_back(v(0, 1, 32'h43, 0, 0, 0, 0, 1, 2, 0));
    vecs.push_back(v(0, 1, 32'h44, 0, 0, 0, 0, 1, 2, 0));
    vecs.push_back(v(0, 1, 32'h45, 0, 0, 0, 0, 1, 2, 1));
    // amount=0: done stays high and nothing is written.
    vecs.push_back(v(1, 1, 32'h0,  3, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(0, 1, 32'h77, 3, 0, 0, 0, 0, 0, 1));
    // Period larger than amount: no advance.
    vecs.push_back(v(1, 1, 32'h0,  0, 1, 10, 3, 0, 0, 0));
    vecs.push_back(v(0, 1, 32'h51, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 1, 32'h52, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 1, 32'h53, 0, 0, 0, 0, 1, 0, 1));

    // Reset state.
    #2 rst = 1'b1;
    repeat (2) tick();
    chk_all("reset");
    chk("reset done", {31'd0, done}, 32'd1);
    @(negedge clk) rst = 1'b0;
    tick();

    foreach (vecs[k]) begin
      run = vecs[k].run; running = vecs[k].running; in0 = vecs[k].in0;
      sel = vecs[k].sel; auto_rr = vecs[k].auto_rr;
      period = vecs[k].period; amount = vecs[k].amount;
      tick();
      if (vecs[k].wr) begin
        for (int i = 0; i < 4; i++)
          if (ZERO && i != int'(vecs[k].widx)) exp_out[i] = '0;
        exp_out[vecs[k].widx] = vecs[k].in0;
      end
      chk_all($sformatf("vec%0d", k));
      chk($sformatf("vec%0d done", k), {31'd0, done}, {31'd0, vecs[k].done});
    end
    run = 1'b0;

    // Unselected-output clear: out2 holds 0x55, then a single word to out0.
    run = 1; sel = 2; auto_rr = 0; amount = 1; tick();
    run = 0; in0 = 32'h55; tick();
    chk("zu out2 first", out2, 32'h55);
    run = 1; sel = 0; amount = 1; tick();
    run = 0; in0 = 32'h11; tick();
    chk("zu out0", out0, 32'h11);
    chk("zu out2 after", out2, ZERO ? 32'h0 : 32'h55);
    chk("zu done", {31'd0, done}, 32'd1);

    // Async reset mid-transfer of 8 words.
    run = 1; sel = 1; auto_rr = 0; amount = 8; tick();
    run = 0; in0 = 32'h61; tick();
    in0 = 32'h62; tick();
    chk("rm out1 pre", out1, 32'h62);
    chk("rm done pre", {31'd0, done}, 32'd0);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) exp_out[i] = '0;
    chk_all("rm async");
    chk("rm async done", {31'd0, done}, 32'd1);
    tick();
    rst = 1'b0;
    in0 = 32'h63; running = 1;
    repeat (3) tick();
    chk_all("rm after");
    chk("rm after done", {31'd0, done}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/demux4_seq.md
Name: demux4_seq

Overview:
- Versat functional unit, inverse of the 4:1 mux unit: routes one input stream to one of four registered outputs.
- Distributes a bounded number of words after each run pulse, either to a fixed output or round-robin across out0..out3, advancing every PERIOD words.
- Sits in the Versat datapath alongside the other units, driven by the standard clk/rst/run/running controls; done feeds the accelerator done-reduction.

Parameters:
- DATA_W, 32, data width of in0 and out0..out3.
- CNT_W, 16, width of the amount, period and internal counters.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- running  input  1  accelerator running; low = stall, no state change.
- run  input  1  single-cycle start pulse, sampled at posedge clk.
- done  output  1  high when idle / transfer complete.
- in0  input  DATA_W  input data word.
- out0, out1, out2, out3  output  DATA_W each  registered data outputs, versat_latency = 1.
- sel  input  2  start output index, sampled on run.
- auto_rr  input  1  1 = round-robin advance, 0 = fixed output; sampled on run.
- period  input  CNT_W  words per output before advancing in auto_rr mode; 0 is treated as 1; sampled on run.
- amount  input  CNT_W  words to route after run; 0 = nothing routed; sampled on run.

Behaviour:
- Reset (async, rst high):
  - state IDLE; out0..out3 = 0; done = 1.
  - idx = 0; per_cnt = 0; item_cnt = 0; all shadow config registers = 0.
- Config latch on run:
  - sel, auto_rr, period and amount are captured on the cycle run is high.
  - Later changes to these inputs are ignored until the next run.
- run high (any state, regardless of running):
  - idx <= sel; per_cnt <= 0; item_cnt <= 0.
  - If amount != 0: state <= ACTIVE, done <= 0. Otherwise state stays/returns IDLE, done = 1.
  - No data write occurs on the run cycle.
  - run while ACTIVE aborts the current transfer and restarts it.
- ACTIVE and running=1, each cycle:
  - out[idx] <= in0. Latency 1: a word on in0 at edge t is visible on out[idx] after edge t.
  - The other three outputs hold their value.
  - item_cnt += 1.
  - If auto_rr=1: per_cnt += 1. When per_cnt == max(period,1)-1, then per_cnt <= 0 and idx <= idx+1 mod 4 (3 wraps to 0).
  - If auto_rr=0: idx is fixed for the whole transfer.
  - When item_cnt == amount-1 on a write cycle, that write completes, then state <= IDLE and done <= 1 at the same edge. The last word and done are visible together.
- ACTIVE and running=0: full stall; outputs, counters, idx and done all hold.
- IDLE: outputs hold their last values; in0 is ignored; done = 1.
- Counters: item_cnt and per_cnt are CNT_W unsigned and never exceed amount-1 / period-1.
  - amount = 2^CNT_W-1 is legal.
  - period larger than amount is legal: no advance occurs.
- rst mid-transfer: immediate return to the reset values above; the partial transfer is lost.

Optional Feature:
- Macro: DEMUX4_SEQ_ZERO_UNSEL_EN.
- Defined: on every ACTIVE write cycle with running=1, the three non-selected outputs are cleared to 0. In IDLE and stall cycles all outputs still hold.
- Undefined: non-selected outputs hold their last written value, as described in Behaviour.

Test Plan:
- Reset: assert rst mid-transfer of amount=8 -> out0..out3 = 0 and done = 1 immediately; no writes until the next run.
- Fixed route: sel=2, auto_rr=0, amount=3, in0 = 0xA, 0xB, 0xC on consecutive running cycles -> out2 shows 0xA, 0xB, 0xC with 1-cycle latency; out0/1/3 stay 0; done rises with the 0xC write.
- Round-robin: sel=3, auto_rr=1, period=2, amount=6, in0 = 1..6 -> 1,2 to out3; 3,4 to out0 (wrap 3 -> 0); 5,6 to out1; final values out3=2, out0=4, out1=6.
- Stall and period=0: auto_rr=1, period=0, amount=4, running low for 2 cycles after the first word -> behaves as period=1, indices 0,1,2,3; no writes or counter changes during the stall; done after 4 writes.
- Restart and amount=0: run again after 2 of 5 words -> counters reset, idx reloads sel, 5 new words routed. A run with amount=0 keeps done = 1 and writes nothing.
- DEMUX4_SEQ_ZERO_UNSEL_EN: out2 = 0x55 from an earlier transfer, then a fixed route to out0 of 0x11 -> out2 reads 0 after the first write. With the macro undefined, out2 stays 0x55.
